ysyx_22050612_ifu: RTL
======================

Name: ysyx_22050612_ifu

Overview:
Instruction fetch stage sitting directly upstream of the decode/execute path.
- Holds the architectural PC and issues one word-aligned fetch request at a time to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Presents the fetched instruction and its PC to downstream with a valid/ready handshake.
- Loads the next PC from the downstream dnpc result when the instruction is accepted.

Parameters:
RESET_PC  64'h0000_0000_8000_0000  PC loaded on reset
TIMEOUT  1024  max cycles in S_WAIT before fetch error; 0 disables the watchdog

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
dnpc  input  64  next PC from downstream; sampled only on inst handshake
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  64  fetch address, always equal to pc
mem_resp_valid  input  1  response data valid, single-cycle pulse
mem_resp_data  input  32  fetched instruction word
inst_valid  output  1  instruction available to downstream
inst_ready  input  1  downstream accepts instruction
inst  output  32  registered instruction word
pc  output  64  PC of the current fetch/instruction
fetch_err  output  1  sticky error flag
err_code  output  2  0 none, 1 misaligned dnpc, 2 response timeout
fetch_cnt  output  64  count of accepted instructions

Behaviour:
Reset (rst=1 at clock edge), regardless of state:
- state=S_REQ, pc=RESET_PC, inst=0, fetch_err=0, err_code=0, fetch_cnt=0, wait counter=0.
- Outputs during and immediately after reset: mem_req_valid=1 (in S_REQ), inst_valid=0.
- Reset mid-fetch abandons the outstanding request; memory shares rst, and any resp arriving outside S_WAIT is ignored.

States:
- S_REQ: mem_req_valid=1, mem_req_addr=pc. On mem_req_ready=1 -> S_WAIT, clear wait counter. A mem_resp_valid in S_REQ is ignored; the response is never accepted in the same cycle as the request.
- S_WAIT: mem_req_valid=0.
  - On mem_resp_valid=1: inst<=mem_resp_data -> S_VALID.
  - Else the wait counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no response -> S_ERR, err_code=2.
  - A response in the same cycle the counter hits the limit wins: go to S_VALID.
- S_VALID: inst_valid=1; inst and pc held stable until handshake.
  - On inst_ready=1: fetch_cnt+=1 and pc<=dnpc.
  - If dnpc[1:0]!=0: pc still loads dnpc -> S_ERR, err_code=1.
  - Else -> S_REQ.
  - No new request is issued before the handshake (one instruction in flight).
- S_ERR: mem_req_valid=0, inst_valid=0, fetch_err=1, err_code held. Exited only by rst.

Other rules:
- Minimum latency request-accept to inst_valid = 2 cycles (accept edge, response edge). Back-to-back throughput with ready memory and downstream is 1 instruction per 3 cycles.
- fetch_cnt wraps modulo 2^64.
- pc arithmetic is done downstream; this block never adds to pc.
- inst_ready while inst_valid=0 has no effect.
- All outputs are driven from registers or the state decode only; there is no combinational path from inst_ready or mem_resp_* to the outputs.

Test Plan:
- Reset, mem_req_ready=1, response 1 cycle later with 32'h00000513, inst_ready=1, dnpc=pc+4 -> mem_req_addr=0x80000000, inst_valid rises 2 cycles after request accept with inst=0x00000513; next mem_req_addr=0x80000004; fetch_cnt=1.
- Hold mem_req_ready=0 for 5 cycles, then 1 -> mem_req_valid=1 and addr stable at 0x80000000 throughout; exactly one request accepted.
- Response captured, inst_ready=0 for 4 cycles with a stray mem_resp_valid pulse carrying 0xDEADBEEF -> inst stays at its first value, inst_valid=1, pc unchanged, fetch_cnt unchanged until ready.
- At handshake, dnpc=0x80000102 -> pc=0x80000102, fetch_err=1, err_code=1, mem_req_valid=0 until rst; after rst, pc=0x80000000.
- TIMEOUT=8, no response -> fetch_err=1 with err_code=2 exactly 8 cycles after request accept. Repeat with the response on the 8th cycle -> inst_valid=1 and no error.
- Assert rst while in S_WAIT, and deliver a response 1 cycle after rst deasserts -> response ignored; state=S_REQ, pc=0x80000000, inst_valid=0, fetch_cnt=0.

Source files
------------

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch stage: owns the PC and fetches one word per instruction.
// Each instruction is presented downstream and the PC is reloaded from dnpc.
module ysyx_22050612_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] dnpc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] pc,
    output logic        fetch_err,
    output logic [1:0]  err_code,
    output logic [63:0] fetch_cnt,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never depends combinationally on ready, and the
    // response channel has no ready (a resp is taken only in S_WAIT).
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] wait_cnt;
    logic        timeout_hit;
    logic        dnpc_misaligned;

    assign timeout_hit     = (TIMEOUT != 0) && (wait_cnt == TIMEOUT - 1);
    assign dnpc_misaligned = (dnpc[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   if (mem_req_ready) state_d = S_WAIT;
            S_WAIT: begin
                // A response arriving on the limit cycle still wins.
                if (mem_resp_valid)   state_d = S_VALID;
                else if (timeout_hit) state_d = S_ERR;
            end
            S_VALID: begin
                if (inst_ready) state_d = dnpc_misaligned ? S_ERR : S_REQ;
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_REQ;
            pc        <= RESET_PC;
            inst      <= 32'd0;
            err_code  <= 2'd0;
            fetch_cnt <= 64'd0;
            wait_cnt  <= 32'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_REQ: if (mem_req_ready) wait_cnt <= 32'd0;
                S_WAIT: begin
                    if (mem_resp_valid)   inst     <= mem_resp_data;
                    else if (timeout_hit) err_code <= 2'd2;
                    else                  wait_cnt <= wait_cnt + 32'd1;
                end
                S_VALID: begin
                    if (inst_ready) begin
                        fetch_cnt <= fetch_cnt + 64'd1;
                        pc        <= dnpc;
                        if (dnpc_misaligned) err_code <= 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_valid = (state_q == S_REQ);
    assign mem_req_addr  = pc;
    assign inst_valid    = (state_q == S_VALID);
    assign fetch_err     = (state_q == S_ERR);
    assign dbg_state     = state_q;

endmodule
